// File: rtl/rca4_bist.sv
// rca4_bist - exhaustive built-in self-test controller for a 4-bit
// ripple-carry adder.
//
// The controller walks all 512 input combinations {ci, a, b}, gives the
// adder SETTLE cycles to produce a result, and then compares {co, s}
// against a golden sum computed here. It keeps a mismatch count and
// captures the first failing vector.
//
// Parameters:
//   SETTLE      settle cycles per vector before the check (1..15)
// Ports:
//   clk         system clock, rising-edge
//   reset_n     synchronous active-low reset
//   start       begin a run (honoured only when idle or done)
//   dut_a/b/ci  operands driven to the adder, registered from the vector index
//   dut_s/co    sum and carry returned by the adder
//   busy        run in progress
//   done        run finished; held until the next start or reset
//   pass        done with zero mismatches
//   err_cnt     number of mismatching vectors so far
//   fail_valid  a failing vector has been captured in this run
//   fail_vec    index {ci, a, b} of the first failing vector

module rca4_bist #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  output logic [3:0] dut_a,
  output logic [3:0] dut_b,
  output logic       dut_ci,
  input  logic [3:0] dut_s,
  input  logic       dut_co,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [9:0] err_cnt,
  output logic       fail_valid,
  output logic [8:0] fail_vec
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Counter is loaded with SETTLE-1 so that SETTLE state lasts SETTLE cycles.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  state_t      state_reg;
  state_t      state_next;
  logic [8:0]  vec_reg;
  logic [3:0]  settle_cnt_reg;
  logic [9:0]  err_cnt_reg;
  logic        fail_valid_reg;
  logic [8:0]  fail_vec_reg;

  logic [4:0]  exp_sum;
  logic [4:0]  dut_res;
  logic [4:0]  bit_mismatch;
  logic        mismatch;
  logic        start_run;
  logic        last_vec;

  // Golden result is derived from the vector currently on the pins.
  assign exp_sum = {1'b0, vec_reg[7:4]} + {1'b0, vec_reg[3:0]} + {4'b0000, vec_reg[8]};
  assign dut_res = {dut_co, dut_s};

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_cmp
      assign bit_mismatch[gi] = dut_res[gi] ^ exp_sum[gi];
    end
  endgenerate

  assign mismatch  = |bit_mismatch;
  assign last_vec  = (vec_reg == 9'd511);
  // start is ignored while a run is in progress.
  assign start_run = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (start_run) state_next = ST_SETTLE;
      ST_SETTLE: if (settle_cnt_reg == 4'd0) state_next = ST_CHECK;
      ST_CHECK:  state_next = last_vec ? ST_DONE : ST_SETTLE;
      ST_DONE:   if (start_run) state_next = ST_SETTLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Datapath: vector index, settle counter and result capture.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vec_reg        <= 9'd0;
      settle_cnt_reg <= 4'd0;
      err_cnt_reg    <= 10'd0;
      fail_valid_reg <= 1'b0;
      fail_vec_reg   <= 9'd0;
    end else if (start_run) begin
      vec_reg        <= 9'd0;
      settle_cnt_reg <= SETTLE_LOAD;
      err_cnt_reg    <= 10'd0;
      fail_valid_reg <= 1'b0;
      fail_vec_reg   <= 9'd0;
    end else begin
      case (state_reg)
        ST_SETTLE: begin
          if (settle_cnt_reg != 4'd0) begin
            settle_cnt_reg <= settle_cnt_reg - 4'd1;
          end
        end
        ST_CHECK: begin
          if (mismatch) begin
            err_cnt_reg <= err_cnt_reg + 10'd1;
            if (!fail_valid_reg) begin
              fail_vec_reg   <= vec_reg;
              fail_valid_reg <= 1'b1;
            end
          end
          // On the last vector the pins keep holding it through DONE.
          if (!last_vec) begin
            vec_reg        <= vec_reg + 9'd1;
            settle_cnt_reg <= SETTLE_LOAD;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode. err_cnt already includes the last vector when DONE is
  // entered, so pass can be decoded straight from it.
  always_comb begin
    busy = (state_reg == ST_SETTLE) || (state_reg == ST_CHECK);
    done = (state_reg == ST_DONE);
    pass = (state_reg == ST_DONE) && (err_cnt_reg == 10'd0);
  end

  assign dut_ci     = vec_reg[8];
  assign dut_a      = vec_reg[7:4];
  assign dut_b      = vec_reg[3:0];
  assign err_cnt    = err_cnt_reg;
  assign fail_valid = fail_valid_reg;
  assign fail_vec   = fail_vec_reg;

endmodule

// File: tb/tb_rca4_bist.sv
// Testbench for rca4_bist: two controller instances (SETTLE=1 and SETTLE=3)
// each driving a behavioural adder. The SETTLE=1 adder can have a fault
// injected. Expected end-of-run results are queued when a run is started;
// monitors pop and compare them when done rises.

module tb_rca4_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       start1, start3;
  logic [1:0] fault;   // 0: good, 1: carry-out stuck 0, 2: sum bit 0 inverted

  logic [3:0] a1, b1, s1, a3, b3, s3;
  logic       ci1, co1, ci3, co3;
  logic       busy1, done1, pass1, fv1, busy3, done3, pass3, fv3;
  logic [9:0] err1, err3;
  logic [8:0] fvec1, fvec3;
  logic [8:0] vec1, vec3;
  logic [4:0] sum1, sum3;

  assign vec1 = {ci1, a1, b1};
  assign vec3 = {ci3, a3, b3};

  // Behavioural adders
  always_comb begin
    sum1 = {1'b0, a1} + {1'b0, b1} + {4'b0000, ci1};
    case (fault)
      2'd1:    sum1 = {1'b0, sum1[3:0]};
      2'd2:    sum1 = {sum1[4:1], ~sum1[0]};
      default: ;
    endcase
  end
  assign {co1, s1} = sum1;
  assign sum3 = {1'b0, a3} + {1'b0, b3} + {4'b0000, ci3};
  assign {co3, s3} = sum3;

  rca4_bist #(.SETTLE(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1),
    .dut_a(a1), .dut_b(b1), .dut_ci(ci1), .dut_s(s1), .dut_co(co1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
    .fail_valid(fv1), .fail_vec(fvec1)
  );

  rca4_bist #(.SETTLE(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .start(start3),
    .dut_a(a3), .dut_b(b3), .dut_ci(ci3), .dut_s(s3), .dut_co(co3),
    .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3),
    .fail_valid(fv3), .fail_vec(fvec3)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [9:0] err;
    logic       fv;
    logic [8:0] fvec;
    logic       pass;
    int         cycles;
  } exp_t;

  exp_t sb1[$];
  exp_t sb3[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) begin
      n_pass++;
      $display("check %s: %0h ok", name, act);
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [9:0] err, input logic fv, input logic [8:0] fvec,
                              input logic pass, input int cycles);
    exp_t e;
    e.err = err; e.fv = fv; e.fvec = fvec; e.pass = pass; e.cycles = cycles;
    return e;
  endfunction

  // Monitor for the SETTLE=1 instance
  initial begin
    int   bcnt = 0;
    logic bprev = 1'b0;
    logic dprev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy1) bcnt = bprev ? bcnt + 1 : 1;
      bprev = busy1;
      if (done1 && !dprev) begin
        if (sb1.size() == 0) begin
          check("dut1_unexpected_done", 32'(done1), 32'd0);
        end else begin
          e = sb1.pop_front();
          check("dut1_err_cnt",    32'(err1),  32'(e.err));
          check("dut1_fail_valid", 32'(fv1),   32'(e.fv));
          check("dut1_fail_vec",   32'(fvec1), 32'(e.fvec));
          check("dut1_pass",       32'(pass1), 32'(e.pass));
          check("dut1_busy_len",   32'(bcnt),  32'(e.cycles));
          check("dut1_busy_low",   32'(busy1), 32'd0);
        end
      end
      dprev = done1;
    end
  end

  // Monitor for the SETTLE=3 instance
  initial begin
    int   bcnt = 0;
    logic bprev = 1'b0;
    logic dprev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy3) bcnt = bprev ? bcnt + 1 : 1;
      bprev = busy3;
      if (done3 && !dprev) begin
        if (sb3.size() == 0) begin
          check("dut3_unexpected_done", 32'(done3), 32'd0);
        end else begin
          e = sb3.pop_front();
          check("dut3_err_cnt",  32'(err3),  32'(e.err));
          check("dut3_pass",     32'(pass3), 32'(e.pass));
          check("dut3_busy_len", 32'(bcnt),  32'(e.cycles));
        end
      end
      dprev = done3;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse1();
    start1 = 1'b1; tick(); start1 = 1'b0;
  endtask

  task automatic wait_done1(input string name);
    for (int i = 0; i < 3000; i++) begin
      if (done1) break;
      tick();
    end
    if (!done1) check(name, 32'(done1), 32'd1);
  endtask

  task automatic wait_vec1(input logic [8:0] v, input string name);
    for (int i = 0; i < 3000; i++) begin
      if (vec1 == v) break;
      tick();
    end
    if (vec1 != v) check(name, 32'(vec1), 32'(v));
  endtask

  task automatic check_zero1(input string name);
    check({name, "_pins"},  32'(vec1),  32'd0);
    check({name, "_busy"},  32'(busy1), 32'd0);
    check({name, "_done"},  32'(done1), 32'd0);
    check({name, "_pass"},  32'(pass1), 32'd0);
    check({name, "_err"},   32'(err1),  32'd0);
    check({name, "_fv"},    32'(fv1),   32'd0);
    check({name, "_fvec"},  32'(fvec1), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; start1 = 1'b0; start3 = 1'b0; fault = 2'd0;
    repeat (3) tick();
    check_zero1("reset");
    check("reset_dut3_busy_done", 32'({busy3, done3, vec3}), 32'd0);
    reset_n = 1'b1;
    tick();
    check("idle_no_start", 32'({busy1, done1}), 32'd0);

    // Run A: good adder, start pulses during busy must be ignored
    sb1.push_back(mk(10'd0, 1'b0, 9'd0, 1'b1, 1024));
    pulse1();
    check("runA_busy_after_start", 32'(busy1), 32'd1);
    check("runA_vec0_on_pins",     32'(vec1),  32'd0);
    repeat (100) tick();
    pulse1();
    repeat (37) tick();
    pulse1();
    wait_done1("runA_done_timeout");
    repeat (3) tick();
    check("runA_done_held", 32'(done1), 32'd1);
    check("runA_pins_hold", 32'(vec1),  32'd511);

    // Run B: carry-out stuck at 0
    fault = 2'd1;
    sb1.push_back(mk(10'd256, 1'b1, 9'h01F, 1'b0, 1024));
    pulse1();
    wait_vec1(9'h020, "runB_vec32_timeout");
    check("runB_midrun_err",  32'(err1),  32'd1);
    check("runB_midrun_fvec", 32'(fvec1), 32'h01F);
    wait_done1("runB_done_timeout");

    // Run C: restart from DONE after the failing run, fault removed
    fault = 2'd0;
    sb1.push_back(mk(10'd0, 1'b0, 9'd0, 1'b1, 1024));
    pulse1();
    check("runC_err_cleared",  32'(err1),  32'd0);
    check("runC_fv_cleared",   32'(fv1),   32'd0);
    check("runC_done_cleared", 32'(done1), 32'd0);
    check("runC_pass_cleared", 32'(pass1), 32'd0);
    wait_done1("runC_done_timeout");

    // Run D: sum bit 0 inverted
    fault = 2'd2;
    sb1.push_back(mk(10'd512, 1'b1, 9'h000, 1'b0, 1024));
    pulse1();
    wait_done1("runD_done_timeout");

    // Run E: reset in the middle of a run, then a clean full run
    fault = 2'd1;
    pulse1();
    wait_vec1(9'd300, "runE_vec300_timeout");
    reset_n = 1'b0;
    tick();
    check_zero1("midrun_reset");
    reset_n = 1'b1;
    tick();
    check("after_reset_idle", 32'({busy1, done1}), 32'd0);
    fault = 2'd0;
    sb1.push_back(mk(10'd0, 1'b0, 9'd0, 1'b1, 1024));
    pulse1();
    wait_done1("runE_done_timeout");

    // SETTLE=3 instance: pins step every 4 cycles, run lasts 2048 cycles
    sb3.push_back(mk(10'd0, 1'b0, 9'd0, 1'b1, 2048));
    start3 = 1'b1; tick(); start3 = 1'b0;
    repeat (19) tick();
    check("s3_vec4_at_19", 32'(vec3), 32'd4);
    tick();
    check("s3_vec5_at_20", 32'({ci3, a3, b3}), 32'h005);
    for (int i = 0; i < 5000; i++) begin
      if (done3) break;
      tick();
    end
    if (!done3) check("s3_done_timeout", 32'(done3), 32'd1);

    tick();
    check("sb1_drained", 32'(sb1.size()), 32'd0);
    check("sb3_drained", 32'(sb3.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
